// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, register-file constants and writeback entry type
package pipeline_pkg;
  localparam int DATA_W = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_queue.sv
// wb_queue: in-order FIFO with two ordered write ports (d0 before d1) and one read port
module wb_queue import pipeline_pkg::*; #(
  parameter int W = $bits(wb_entry_t),
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we0,
  input  logic [W-1:0]  d0,
  input  logic          we1,
  input  logic [W-1:0]  d1,
  input  logic          re,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty
);
  logic [W-1:0] ram [DEPTH];
  logic [AW-1:0] wp, rp;
  // storage needs no reset; we1 is only raised together with we0
  always_ff @(posedge clk) begin
    if (we0) ram[wp] <= d0;
    if (we1) ram[wp + AW'(1)] <= d1;
  end
  // pointers wrap naturally at the power-of-two depth; count kept separately
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(we0) + AW'(we1);
      rp <= rp + AW'(re);
      count <= count + CW'(we0) + CW'(we1) - CW'(re);
    end
  assign head = ram[rp];
  assign empty = count == '0;
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU and load results onto the single register-file write port with a pending-write scoreboard
module writeback_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              in_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  output logic [7:0]        pending_mask,
  output logic              enableWrite,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] BusW
);
  import pipeline_pkg::*;
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int W = ADDR_W + DATA_W;
  logic [CW-1:0] count;
  logic empty, m, a, we0, we1, nxt_v;
  logic [W-1:0] head, d0, d1, nxt, mem_e, alu_e;
  logic [1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc, dec;
  assign in_ready = count <= CW'(QDEPTH - 2);
  assign m = in_ready && mem_valid && mem_rd != ADDR_W'(REG_ZERO);
  assign a = in_ready && alu_valid && alu_rd != ADDR_W'(REG_ZERO);
  assign mem_e = {mem_rd, mem_data};
  assign alu_e = {alu_rd, alu_data};
  // an empty queue forwards the oldest new result straight to the write port; the rest is queued mem-first
  always_comb begin
    we0 = empty ? m && a : m || a;
    we1 = !empty && m && a;
    d0 = (empty || !m) ? alu_e : mem_e;
    d1 = alu_e;
    nxt_v = !empty || m || a;
    nxt = !empty ? head : m ? mem_e : alu_e;
  end
  wb_queue #(.W(W), .DEPTH(QDEPTH)) u_q (
    .clk(clk), .rst(reset), .we0(we0), .d0(d0), .we1(we1), .d1(d1),
    .re(!empty), .head(head), .count(count), .empty(empty)
  );
  // write-port registers hold their last value when nothing is written
  always_ff @(posedge clk)
    if (reset) begin
      enableWrite <= 1'b0;
      RW <= '0;
      BusW <= '0;
    end else begin
      enableWrite <= nxt_v;
      if (nxt_v) {RW, BusW} <= nxt;
    end
  // per-register increment on issue, decrement when its write is on the port
  always_comb
    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i] = issue_valid && issue_rd == ADDR_W'(i) && i != 0;
      dec[i] = enableWrite && RW == ADDR_W'(i);
      pending_mask[i] = cnt[i] != 2'd0;
    end
  // pending counters saturate at 3 and never go below 0; R0 stays 0
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_REGS; i++)
      if (reset || i == 0) cnt[i] <= 2'd0;
      else if (inc[i] && !dec[i] && cnt[i] != 2'd3) cnt[i] <= cnt[i] + 2'd1;
      else if (dec[i] && !inc[i] && cnt[i] != 2'd0) cnt[i] <= cnt[i] - 2'd1;
  assign issue_ready = cnt[issue_rd] != 2'd3;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed vector table plus backpressure and reset sequences
module tb_writeback_arbiter;
  logic clk = 0, reset = 1;
  logic alu_valid = 0, mem_valid = 0, issue_valid = 0;
  logic [2:0] alu_rd = 0, mem_rd = 0, issue_rd = 0;
  logic [15:0] alu_data = 0, mem_data = 0;
  logic in_ready, issue_ready, enableWrite;
  logic [7:0] pending_mask;
  logic [2:0] RW;
  logic [15:0] BusW;
  int n_cmp = 0, n_err = 0;

  writeback_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .in_ready(in_ready), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .pending_mask(pending_mask),
    .enableWrite(enableWrite), .RW(RW), .BusW(BusW)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic av; logic [2:0] ar; logic [15:0] ad;
    logic mv; logic [2:0] mr; logic [15:0] md;
    logic iv; logic [2:0] ir;
    logic e_en; logic [2:0] e_rw; logic [15:0] e_bw;
    logic [7:0] e_pm; logic e_inr; logic e_isr;
  } vec_t;

  function automatic vec_t mk(logic av, logic [2:0] ar, logic [15:0] ad,
                              logic mv, logic [2:0] mr, logic [15:0] md,
                              logic iv, logic [2:0] ir,
                              logic e_en, logic [2:0] e_rw, logic [15:0] e_bw,
                              logic [7:0] e_pm, logic e_inr, logic e_isr);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
    v.iv = iv; v.ir = ir; v.e_en = e_en; v.e_rw = e_rw; v.e_bw = e_bw;
    v.e_pm = e_pm; v.e_inr = e_inr; v.e_isr = e_isr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
  endtask

  vec_t tbl[16];
  logic [18:0] expq[$];
  logic [18:0] e;
  int k;
  logic saw_low;

  initial begin
    tbl[0]  = mk(0,0,16'h0,    0,0,16'h0,    0,0, 0,0,16'h0,    8'h00,1,1);
    tbl[1]  = mk(0,0,16'h0,    0,0,16'h0,    1,3, 0,0,16'h0,    8'h08,1,1);
    tbl[2]  = mk(1,3,16'h1234, 0,0,16'h0,    0,0, 1,3,16'h1234, 8'h08,1,1);
    tbl[3]  = mk(0,0,16'h0,    0,0,16'h0,    0,0, 0,3,16'h1234, 8'h00,1,1);
    tbl[4]  = mk(0,0,16'h0,    0,0,16'h0,    1,5, 0,3,16'h1234, 8'h20,1,1);
    tbl[5]  = mk(0,0,16'h0,    0,0,16'h0,    1,5, 0,3,16'h1234, 8'h20,1,1);
    tbl[6]  = mk(1,5,16'h5555, 1,5,16'hAAAA, 0,0, 1,5,16'hAAAA, 8'h20,1,1);
    tbl[7]  = mk(0,0,16'h0,    0,0,16'h0,    0,0, 1,5,16'h5555, 8'h20,1,1);
    tbl[8]  = mk(0,0,16'h0,    0,0,16'h0,    0,0, 0,5,16'h5555, 8'h00,1,1);
    tbl[9]  = mk(1,0,16'hFFFF, 0,0,16'h0,    0,0, 0,5,16'h5555, 8'h00,1,1);
    tbl[10] = mk(0,0,16'h0,    0,0,16'h0,    0,0, 0,5,16'h5555, 8'h00,1,1);
    tbl[11] = mk(0,0,16'h0,    0,0,16'h0,    1,2, 0,5,16'h5555, 8'h04,1,1);
    tbl[12] = mk(0,0,16'h0,    0,0,16'h0,    1,2, 0,5,16'h5555, 8'h04,1,1);
    tbl[13] = mk(0,0,16'h0,    0,0,16'h0,    1,2, 0,5,16'h5555, 8'h04,1,0);
    tbl[14] = mk(0,0,16'h0,    0,0,16'h0,    0,4, 0,5,16'h5555, 8'h04,1,1);
    tbl[15] = mk(0,0,16'h0,    0,0,16'h0,    0,2, 0,5,16'h5555, 8'h04,1,0);

    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_en", enableWrite, 0);
    chk("reset_rw", RW, 0);
    chk("reset_busw", BusW, 0);
    chk("reset_pm", pending_mask, 0);
    chk("reset_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      alu_valid = tbl[i].av; alu_rd = tbl[i].ar; alu_data = tbl[i].ad;
      mem_valid = tbl[i].mv; mem_rd = tbl[i].mr; mem_data = tbl[i].md;
      issue_valid = tbl[i].iv; issue_rd = tbl[i].ir;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_en", i), enableWrite, tbl[i].e_en);
      chk($sformatf("v%0d_rw", i), RW, tbl[i].e_rw);
      chk($sformatf("v%0d_busw", i), BusW, tbl[i].e_bw);
      chk($sformatf("v%0d_pm", i), pending_mask, tbl[i].e_pm);
      chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].e_inr);
      chk($sformatf("v%0d_issue_ready", i), issue_ready, tbl[i].e_isr);
    end

    @(negedge clk);
    idle_inputs();
    reset = 1;
    @(negedge clk);
    reset = 0;

    k = 0;
    saw_low = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (in_ready) begin
        mem_valid = 1; mem_rd = 3'(1 + (k % 7)); mem_data = 16'(16'hB000 + k);
        expq.push_back({mem_rd, mem_data});
        k++;
        alu_valid = 1; alu_rd = 3'(1 + (k % 7)); alu_data = 16'(16'hB000 + k);
        expq.push_back({alu_rd, alu_data});
        k++;
      end else begin
        mem_valid = 0; alu_valid = 0;
      end
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d_in_ready", c), in_ready, (c == 2 || c == 4) ? 1'b0 : 1'b1);
      if (!in_ready) saw_low = 1;
      if (enableWrite) begin
        e = expq.pop_front();
        chk($sformatf("bp%0d_rw", c), RW, e[18:16]);
        chk($sformatf("bp%0d_busw", c), BusW, e[15:0]);
      end else chk($sformatf("bp%0d_en", c), enableWrite, 1);
    end
    chk("bp_in_ready_fell", saw_low, 1);
    chk("bp_pushes", k, 8);
    @(negedge clk);
    idle_inputs();
    for (int c = 0; c < 20 && expq.size() > 0; c++) begin
      @(posedge clk);
      #1;
      if (enableWrite) begin
        e = expq.pop_front();
        chk($sformatf("drain%0d_rw", c), RW, e[18:16]);
        chk($sformatf("drain%0d_busw", c), BusW, e[15:0]);
      end else chk($sformatf("drain%0d_en", c), enableWrite, 1);
    end
    chk("drain_left", expq.size(), 0);
    @(posedge clk);
    #1;
    chk("drain_idle_en", enableWrite, 0);
    chk("drain_pm", pending_mask, 0);

    @(negedge clk);
    issue_valid = 1; issue_rd = 6;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("mid_pm", pending_mask, 8'h40);
    @(negedge clk);
    issue_valid = 0;
    mem_valid = 1; mem_rd = 6; mem_data = 16'h6666;
    alu_valid = 1; alu_rd = 6; alu_data = 16'h7777;
    @(posedge clk);
    #1;
    chk("mid_en", enableWrite, 1);
    chk("mid_busw", BusW, 16'h6666);
    @(negedge clk);
    idle_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    chk("rst_mid_en", enableWrite, 0);
    chk("rst_mid_pm", pending_mask, 0);
    chk("rst_mid_rw", RW, 0);
    chk("rst_mid_busw", BusW, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst%0d_en", c), enableWrite, 0);
      chk($sformatf("post_rst%0d_pm", c), pending_mask, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
